led_flow_ctrl: RTL

Parametrised running-light ("streamed LED") controller, successor to the fixed 8-bit two-mode streamed_led. Drives LED_NUM outputs with four selectable patterns, a run/pause enable and a 4-level speed select. Sits directly behind board LED pins; the step rate comes from an internal prescaler on the system clock.

---
 rtl/led_flow_ctrl_if.sv | 21 ++
 rtl/led_flow_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/led_flow_ctrl_if.sv
// led_flow_ctrl_if: control and display bundle of the running-light controller.
//   en         : run (1) / pause (0)
//   mode       : pattern select (00 rol, 01 ror, 10 bounce, 11 bar fill)
//   speed      : pattern advances once every speed+1 base ticks
//   led        : LED drive, 1 = on
//   step_pulse : one-cycle strobe when led takes a new pattern value
//   dir        : bounce direction (0 toward MSB, 1 toward LSB)
// The master modport is the controlling side; the slave modport is the controller.
interface led_flow_ctrl_if #(
  parameter int LED_NUM = 8
);
  logic               en;
  logic [1:0]         mode;
  logic [1:0]         speed;
  logic [LED_NUM-1:0] led;
  logic               step_pulse;
  logic               dir;

  modport master (output en, mode, speed, input led, step_pulse, dir);
  modport slave  (input en, mode, speed, output led, step_pulse, dir);
endinterface

// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: parametrised running-light controller with four patterns,
// run/pause and a four-level speed select.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : led_flow_ctrl_if.slave (en, mode, speed in; led, step_pulse, dir out)
// A prescaler divides clk into base ticks of TICK_DIV cycles; every speed+1
// ticks the pattern steps. A change of mode re-initialises the pattern and
// restarts all counters, taking priority over a coincident step.
module led_flow_ctrl #(
  parameter int LED_NUM  = 8,
  parameter int TICK_DIV = 1_000_000
) (
  input  logic           clk,
  input  logic           rst,
  led_flow_ctrl_if.slave bus
);

  localparam int                 PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]      PRESC_MAX    = PW'(TICK_DIV - 1);
  localparam logic [LED_NUM-1:0] ONE_HOT_LSB  = {{(LED_NUM-1){1'b0}}, 1'b1};
  localparam logic [LED_NUM-1:0] ONE_HOT_MSB  = {1'b1, {(LED_NUM-1){1'b0}}};

  logic [1:0]         mode_reg;
  logic [LED_NUM-1:0] led_reg;
  logic [PW-1:0]      presc_reg;
  logic [1:0]         step_cnt_reg;
  logic               dir_reg;
  logic               step_pulse_reg;

  logic [LED_NUM-1:0] led_next;
  logic               dir_next;
  logic [LED_NUM-1:0] init_led;
  logic [LED_NUM-1:0] rol_led;
  logic [LED_NUM-1:0] ror_led;
  logic [LED_NUM-1:0] bar_led;
  logic               tick;
  logic               mode_change;
  logic               all_on;

  assign tick        = (presc_reg == PRESC_MAX);
  assign mode_change = (bus.mode != mode_reg);
  assign all_on      = &led_reg;

  // Per-bit neighbour wiring for the rotate and bar-fill patterns.
  // Bar fill: (led << 1) | 1, collapsing to zero once every LED is lit.
  for (genvar gi = 0; gi < LED_NUM; gi++) begin : g_bit
    assign rol_led[gi] = led_reg[(gi + LED_NUM - 1) % LED_NUM];
    assign ror_led[gi] = led_reg[(gi + 1) % LED_NUM];
    if (gi == 0) begin : g_lsb
      assign bar_led[gi] = ~all_on;
    end else begin : g_upper
      assign bar_led[gi] = ~all_on & led_reg[gi-1];
    end
  end

  always_comb begin
    case (bus.mode)
      2'b01:   init_led = ONE_HOT_MSB;
      2'b11:   init_led = '0;
      default: init_led = ONE_HOT_LSB;
    endcase
  end

  // Pattern value for the next step. Bounce turns around in the same step
  // that reaches an end LED, so each end is shown for one step only.
  always_comb begin
    led_next = led_reg;
    dir_next = dir_reg;
    case (mode_reg)
      2'b00: led_next = rol_led;
      2'b01: led_next = ror_led;
      2'b10: begin
        if (!dir_reg) begin
          led_next = led_reg << 1;
          dir_next = led_next[LED_NUM-1];
        end else begin
          led_next = led_reg >> 1;
          dir_next = ~led_next[0];
        end
      end
      default: led_next = bar_led;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg       <= 2'b00;
      led_reg        <= ONE_HOT_LSB;
      presc_reg      <= '0;
      step_cnt_reg   <= 2'd0;
      dir_reg        <= 1'b0;
      step_pulse_reg <= 1'b0;
    end else if (mode_change) begin
      mode_reg       <= bus.mode;
      led_reg        <= init_led;
      presc_reg      <= '0;
      step_cnt_reg   <= 2'd0;
      dir_reg        <= 1'b0;
      step_pulse_reg <= 1'b0;
    end else begin
      step_pulse_reg <= 1'b0;
      if (bus.en) begin
        presc_reg <= tick ? '0 : presc_reg + 1'b1;
        if (tick) begin
          // >= lets a lowered speed take effect at the very next tick.
          if (step_cnt_reg >= bus.speed) begin
            step_cnt_reg   <= 2'd0;
            led_reg        <= led_next;
            dir_reg        <= dir_next;
            step_pulse_reg <= 1'b1;
          end else begin
            step_cnt_reg <= step_cnt_reg + 2'd1;
          end
        end
      end
    end
  end

  assign bus.led        = led_reg;
  assign bus.step_pulse = step_pulse_reg;
  assign bus.dir        = dir_reg;

endmodule
